// File: rtl/game_state_manager.sv
// game_state_manager: game flow FSM plus gift, score, lives and level bookkeeping.
// Collision events are latched during a frame and acted on at the next startOfFrame.
module game_state_manager #(
  parameter int unsigned NUM_GIFTS    = 4,
  parameter int unsigned NUM_LIVES    = 3,
  parameter int unsigned GIFT_POINTS  = 10,
  parameter int unsigned WIN_BONUS    = 50,
  parameter int unsigned PAUSE_FRAMES = 60,
  parameter int unsigned SCORE_W      = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             startOfFrame,
  input  logic                             start_key,
  input  logic                             Remove_Gift,
  input  logic                             victory,
  input  logic                             Loss,
  output logic                             gift_clear,
  output logic [$clog2(NUM_GIFTS+1)-1:0]   gifts_left,
  output logic [SCORE_W-1:0]               score,
  output logic [$clog2(NUM_LIVES+1)-1:0]   lives,
  output logic [2:0]                       level,
  output logic [2:0]                       game_state,
  output logic                             freeze,
  output logic                             level_restart
);
  localparam int unsigned GW  = $clog2(NUM_GIFTS+1);
  localparam int unsigned LW  = $clog2(NUM_LIVES+1);
  localparam int unsigned PW  = $clog2(PAUSE_FRAMES+2);
  localparam int unsigned SW1 = SCORE_W + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    WIN  = 3'd2,
    DIE  = 3'd3,
    OVER = 3'd4
  } state_t;

  state_t          state, next_state;
  logic            gift_f, win_f, loss_f, prev_gift;
  logic [PW-1:0]   pause_cnt;
  logic            key_q, restart_q;
  logic            in_play, key_rise, gift_cnt, pause_done;
  logic [SW1-1:0]  add_amt, score_sum;
  logic [SCORE_W-1:0] score_next;

  always_comb begin
    in_play    = (state == PLAY);
    key_rise   = start_key & ~key_q;
    gift_cnt   = gift_f & ~prev_gift & (gifts_left != '0);
    pause_done = (pause_cnt <= PW'(1));
    add_amt    = (win_f && gift_clear) ? SW1'(WIN_BONUS) : SW1'(GIFT_POINTS);
    // One extra bit catches the carry so the score clamps instead of wrapping.
    score_sum  = {1'b0, score} + add_amt;
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (key_rise) next_state = PLAY;
      PLAY: if (startOfFrame) begin
              if (loss_f)                   next_state = DIE;
              else if (win_f && gift_clear) next_state = WIN;
            end
      WIN:  if (startOfFrame && pause_done) next_state = PLAY;
      DIE:  if (startOfFrame && pause_done) next_state = (lives == '0) ? OVER : PLAY;
      OVER: if (key_rise) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    game_state    = state;
    freeze        = (state != PLAY);
    level_restart = restart_q;
    gift_clear    = (gifts_left == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gift_f     <= 1'b0;
      win_f      <= 1'b0;
      loss_f     <= 1'b0;
      prev_gift  <= 1'b0;
      pause_cnt  <= '0;
      key_q      <= 1'b0;
      restart_q  <= 1'b0;
      score      <= '0;
      lives      <= LW'(NUM_LIVES);
      level      <= '0;
      gifts_left <= GW'(NUM_GIFTS);
    end else begin
      key_q     <= start_key;
      restart_q <= (next_state == PLAY) && (state != PLAY);

      // Flags restart on the frame boundary but still capture that cycle's inputs.
      if (startOfFrame) begin
        gift_f    <= in_play & Remove_Gift;
        win_f     <= in_play & victory;
        loss_f    <= in_play & Loss;
        prev_gift <= gift_f;
      end else begin
        gift_f <= gift_f | (in_play & Remove_Gift);
        win_f  <= win_f  | (in_play & victory);
        loss_f <= loss_f | (in_play & Loss);
      end

      case (state)
        PLAY: if (startOfFrame) begin
                if (loss_f) begin
                  if (lives != '0) lives <= lives - LW'(1);
                  pause_cnt <= PW'(PAUSE_FRAMES);
                end else if (win_f && gift_clear) begin
                  score     <= score_next;
                  pause_cnt <= PW'(PAUSE_FRAMES);
                end else if (gift_cnt) begin
                  gifts_left <= gifts_left - GW'(1);
                  score      <= score_next;
                end
              end
        WIN, DIE: if (startOfFrame) begin
                if (pause_done) begin
                  pause_cnt <= '0;
                  if (state == WIN) begin
                    if (level != 3'd7) level <= level + 3'd1;
                    gifts_left <= GW'(NUM_GIFTS);
                  end else if (lives != '0) begin
                    gifts_left <= GW'(NUM_GIFTS);
                  end
                end else begin
                  pause_cnt <= pause_cnt - PW'(1);
                end
              end
        OVER: if (key_rise) begin
                score      <= '0;
                lives      <= LW'(NUM_LIVES);
                level      <= '0;
                gifts_left <= GW'(NUM_GIFTS);
              end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_game_state_manager.sv
// Scoreboard bench for game_state_manager: directed frames push expected snapshots,
// a monitor compares them after each startOfFrame and on asynchronous reset.
module tb_game_state_manager;
  localparam int S_IDLE = 0, S_PLAY = 1, S_WIN = 2, S_DIE = 3, S_OVER = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame, start_key, Remove_Gift, victory, Loss;
  logic       gift_clear, freeze, level_restart;
  logic [2:0] gifts_left, level, game_state;
  logic [6:0] score;
  logic [1:0] lives;

  always #5 clk = ~clk;

  game_state_manager #(
    .NUM_GIFTS(4), .NUM_LIVES(3), .GIFT_POINTS(10),
    .WIN_BONUS(50), .PAUSE_FRAMES(60), .SCORE_W(7)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_key(start_key),
    .Remove_Gift(Remove_Gift), .victory(victory), .Loss(Loss),
    .gift_clear(gift_clear), .gifts_left(gifts_left), .score(score), .lives(lives),
    .level(level), .game_state(game_state), .freeze(freeze), .level_restart(level_restart)
  );

  typedef struct {
    int    frame;
    string name;
    int    st, sc, gl, lv, lvl, rs;
  } exp_t;

  exp_t exp_q[$];
  exp_t rst_q[$];
  int   checks = 0, errors = 0;
  int   frame_no = 0, mon_frame = 0, mon_restarts = 0;
  bit   mon_new = 1'b0;

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic check_snap(input exp_t e);
    cmp({e.name, ".state"},      int'(game_state), e.st);
    cmp({e.name, ".score"},      int'(score),      e.sc);
    cmp({e.name, ".gifts_left"}, int'(gifts_left), e.gl);
    cmp({e.name, ".lives"},      int'(lives),      e.lv);
    cmp({e.name, ".level"},      int'(level),      e.lvl);
    cmp({e.name, ".gift_clear"}, int'(gift_clear), (e.gl == 0) ? 1 : 0);
    cmp({e.name, ".freeze"},     int'(freeze),     (e.st != S_PLAY) ? 1 : 0);
    cmp({e.name, ".restarts"},   mon_restarts,     e.rs);
  endtask

  task automatic build(output exp_t e, input int ahead, input string nm,
                       input int st, input int sc, input int gl, input int lv,
                       input int lvl, input int rs);
    e.frame = frame_no + ahead;
    e.name  = nm;
    e.st = st; e.sc = sc; e.gl = gl; e.lv = lv; e.lvl = lvl; e.rs = rs;
  endtask

  // Expected snapshot after the 'ahead'-th startOfFrame from now.
  task automatic expect_at(input int ahead, input string nm, input int st, input int sc,
                           input int gl, input int lv, input int lvl, input int rs);
    exp_t e;
    build(e, ahead, nm, st, sc, gl, lv, lvl, rs);
    exp_q.push_back(e);
  endtask

  task automatic expect_reset(input string nm, input int rs);
    exp_t e;
    build(e, 0, nm, S_IDLE, 0, 4, 3, 0, rs);
    rst_q.push_back(e);
  endtask

  always @(posedge clk) begin
    if (startOfFrame === 1'b1) begin
      mon_frame++;
      mon_new = 1'b1;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (level_restart) mon_restarts++;
    if (mon_new) begin
      mon_new = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].frame <= mon_frame) begin
        e = exp_q.pop_front();
        if (e.frame < mon_frame) cmp({e.name, ".frame_skipped"}, mon_frame, e.frame);
        else check_snap(e);
      end
    end
  end

  always @(posedge reset) begin
    #1;
    if (rst_q.size() > 0) check_snap(rst_q.pop_front());
  end

  task automatic run_frame(input int len, input bit g, input bit v, input bit l);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      Remove_Gift = g; victory = v; Loss = l;
    end
    @(negedge clk);
    Remove_Gift = 1'b0; victory = 1'b0; Loss = 1'b0;
    frame_no++;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) run_frame(6, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_key();
    @(negedge clk);
    start_key = 1'b1;
    repeat (2) @(negedge clk);
    start_key = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    startOfFrame = 1'b0; start_key = 1'b0;
    Remove_Gift = 1'b0; victory = 1'b0; Loss = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    expect_at(3, "reset_idle", S_IDLE, 0, 4, 3, 0, 0);
    idle_frames(3);
    expect_at(1, "start", S_PLAY, 0, 4, 3, 0, 1);
    press_key(); idle_frames(1);

    // One gift per contiguous overlap run
    expect_at(1, "gift1", S_PLAY, 10, 3, 3, 0, 1);
    run_frame(50, 1, 0, 0);
    expect_at(2, "gift_dup", S_PLAY, 10, 3, 3, 0, 1);
    run_frame(50, 1, 0, 0); run_frame(50, 1, 0, 0);
    expect_at(2, "gift2", S_PLAY, 20, 2, 3, 0, 1);
    idle_frames(1); run_frame(50, 1, 0, 0);
    expect_at(2, "gift3", S_PLAY, 30, 1, 3, 0, 1);
    idle_frames(1); run_frame(6, 1, 0, 0);

    expect_at(1, "win_gated", S_PLAY, 30, 1, 3, 0, 1);
    run_frame(6, 0, 1, 0);
    expect_at(1, "last_gift", S_PLAY, 40, 0, 3, 0, 1);
    run_frame(6, 1, 0, 0);
    expect_at(2, "gift_at_zero", S_PLAY, 40, 0, 3, 0, 1);
    idle_frames(1); run_frame(6, 1, 0, 0);
    expect_at(1, "win", S_WIN, 90, 0, 3, 0, 1);
    run_frame(6, 0, 1, 0);
    expect_at(59, "win_pause", S_WIN, 90, 0, 3, 0, 1);
    idle_frames(59);
    expect_at(1, "next_level", S_PLAY, 90, 4, 3, 1, 2);
    idle_frames(1);

    // Score saturates at 127 with a 7-bit score
    expect_at(1, "sat_g1", S_PLAY, 100, 3, 3, 1, 2);
    run_frame(6, 1, 0, 0);
    expect_at(2, "sat_g2", S_PLAY, 110, 2, 3, 1, 2);
    idle_frames(1); run_frame(6, 1, 0, 0);
    expect_at(2, "sat_g3", S_PLAY, 120, 1, 3, 1, 2);
    idle_frames(1); run_frame(6, 1, 0, 0);
    expect_at(2, "sat_g4", S_PLAY, 127, 0, 3, 1, 2);
    idle_frames(1); run_frame(6, 1, 0, 0);
    expect_at(1, "sat_win", S_WIN, 127, 0, 3, 1, 2);
    run_frame(6, 0, 1, 0);
    expect_at(30, "mid_pause", S_WIN, 127, 0, 3, 1, 2);
    idle_frames(30);

    // Asynchronous reset between clock edges
    expect_reset("async_reset", 2);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_at(1, "post_reset", S_IDLE, 0, 4, 3, 0, 2);
    idle_frames(1);

    expect_at(1, "restart2", S_PLAY, 0, 4, 3, 0, 3);
    press_key(); idle_frames(1);
    for (int k = 1; k <= 4; k++) begin
      expect_at(2, "p2_gift", S_PLAY, 10 * k, 4 - k, 3, 0, 3);
      idle_frames(1); run_frame(6, 1, 0, 0);
    end

    // Loss outranks victory and gift in the same frame
    expect_at(2, "simul", S_DIE, 40, 0, 2, 0, 3);
    idle_frames(1); run_frame(6, 1, 1, 1);
    expect_at(59, "die_pause", S_DIE, 40, 0, 2, 0, 3);
    idle_frames(59);
    expect_at(1, "respawn1", S_PLAY, 40, 4, 2, 0, 4);
    idle_frames(1);
    expect_at(1, "loss2", S_DIE, 40, 4, 1, 0, 4);
    run_frame(6, 0, 0, 1);
    expect_at(60, "respawn2", S_PLAY, 40, 4, 1, 0, 5);
    idle_frames(60);
    expect_at(1, "p2_gift5", S_PLAY, 50, 3, 1, 0, 5);
    run_frame(6, 1, 0, 0);
    expect_at(1, "loss3", S_DIE, 50, 3, 0, 0, 5);
    run_frame(6, 0, 0, 1);
    idle_frames(50);
    start_key = 1'b1;
    expect_at(9, "last_pause", S_DIE, 50, 3, 0, 0, 5);
    idle_frames(9);
    expect_at(1, "over", S_OVER, 50, 3, 0, 0, 5);
    idle_frames(1);
    expect_at(3, "over_held", S_OVER, 50, 3, 0, 0, 5);
    idle_frames(3);
    start_key = 1'b0;
    idle_frames(1);
    expect_at(1, "over_restart", S_IDLE, 0, 4, 3, 0, 5);
    press_key(); idle_frames(1);
    expect_at(2, "idle_stays", S_IDLE, 0, 4, 3, 0, 5);
    idle_frames(2);

    repeat (5) @(negedge clk);
    cmp("pending_checks", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
